// File: rtl/pc_unit_pkg.sv
// Shared encodings and default addresses for the program-counter unit.
package pc_unit_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_op_e;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_HANDLER = 1'b1
    } state_e;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-address candidates: sequential, branch, jump and register targets.
module npc_calc
    import pc_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:2] pc,
    input  npc_op_e           npc_op,
    input  logic              br_taken,
    input  logic [15:0]       imm16,
    input  logic [25:0]       imm26,
    input  logic [ADDR_W-1:2] reg_tgt,
    output logic [ADDR_W-1:2] pc4,
    output logic [ADDR_W-1:2] npc
);

    localparam logic [ADDR_W-1:2] ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

    logic signed [ADDR_W-3:0] br_off;

    assign pc4    = pc + ONE;
    assign br_off = {{(ADDR_W-18){imm16[15]}}, imm16};

    always_comb begin
        npc = pc4;
        case (npc_op)
            NPC_SEQ: npc = pc4;
            NPC_BR:  npc = br_taken ? (pc4 + $unsigned(br_off)) : pc4;
            // Jump keeps the region bits of the sequential address.
            NPC_J:   npc = {pc4[ADDR_W-1:28], imm26};
            NPC_JR:  npc = reg_tgt;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, stall/exception priority, EPC and Redirect.
// Exception support (FSM, EPC, misaligned-JR trap) is built only with PC_EXC_EN defined.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = DEF_RESET_PC[ADDR_W-1:0],
    parameter logic [ADDR_W-1:0] EXC_VECTOR = DEF_EXC_VECTOR[ADDR_W-1:0]
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic [1:0]        NPCOp,
    input  logic              BrTaken,
    input  logic [15:0]       Imm16,
    input  logic [25:0]       Imm26,
    input  logic [ADDR_W-1:0] RegAddr,
    input  logic              ExcReq,
    input  logic              Eret,
    output logic [ADDR_W-1:2] PC,
    output logic [ADDR_W-1:2] PC4,
    output logic [ADDR_W-1:2] EPC,
    output logic              Redirect,
    output logic              InHandler
);

    npc_op_e           op;
    logic [ADDR_W-1:2] pc4;
    logic [ADDR_W-1:2] npc_norm;
    logic [ADDR_W-1:2] pc_nxt;
    logic              load;
    logic              redirect_nxt;

    assign op = npc_op_e'(NPCOp);

    npc_calc #(.ADDR_W(ADDR_W)) u_npc_calc (
        .pc       (PC),
        .npc_op   (op),
        .br_taken (BrTaken),
        .imm16    (Imm16),
        .imm26    (Imm26),
        .reg_tgt  (RegAddr[ADDR_W-1:2]),
        .pc4      (pc4),
        .npc      (npc_norm)
    );

    assign PC4 = pc4;

`ifdef PC_EXC_EN
    state_e            state;
    state_e            state_nxt;
    logic [ADDR_W-1:2] epc;
    logic [ADDR_W-1:2] epc_nxt;
    logic              jr_misalign;

    assign jr_misalign = (op == NPC_JR) && (RegAddr[1:0] != 2'b00);

    // ExcReq only counts in RUN and Eret only in HANDLER; both beat Stall.
    always_comb begin
        state_nxt = state;
        epc_nxt   = epc;
        pc_nxt    = PC;
        load      = 1'b0;
        if (state == ST_RUN) begin
            if (ExcReq || (!Stall && jr_misalign)) begin
                state_nxt = ST_HANDLER;
                epc_nxt   = PC;
                pc_nxt    = EXC_VECTOR[ADDR_W-1:2];
                load      = 1'b1;
            end else if (!Stall) begin
                pc_nxt = npc_norm;
                load   = 1'b1;
            end
        end else begin
            if (Eret) begin
                state_nxt = ST_RUN;
                pc_nxt    = epc;
                load      = 1'b1;
            end else if (!Stall) begin
                pc_nxt = npc_norm;
                load   = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= ST_RUN;
            epc   <= '0;
        end else begin
            state <= state_nxt;
            epc   <= epc_nxt;
        end
    end

    assign EPC       = epc;
    assign InHandler = (state == ST_HANDLER);
`else
    logic unused_exc;

    assign unused_exc = ^{ExcReq, Eret, RegAddr[1:0]};
    assign pc_nxt     = Stall ? PC : npc_norm;
    assign load       = !Stall;
    assign EPC        = '0;
    assign InHandler  = 1'b0;
`endif

    assign redirect_nxt = load && (pc_nxt != pc4);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            PC       <= RESET_PC[ADDR_W-1:2];
            Redirect <= 1'b0;
        end else begin
            PC       <= pc_nxt;
            Redirect <= redirect_nxt;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with a byte-address reference model checked every cycle.
// Exception expectations follow PC_EXC_EN the same way the design does.
module tb_pc_unit;
    import pc_unit_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Stall = 1'b0;
    logic [1:0]  NPCOp = 2'b00;
    logic        BrTaken = 1'b0;
    logic [15:0] Imm16 = '0;
    logic [25:0] Imm26 = '0;
    logic [31:0] RegAddr = '0;
    logic        ExcReq = 1'b0;
    logic        Eret = 1'b0;
    logic [31:2] PC, PC4, EPC;
    logic        Redirect, InHandler;

    int n_vec = 0;
    int n_bad = 0;

`ifdef PC_EXC_EN
    localparam bit EXC = 1'b1;
`else
    localparam bit EXC = 1'b0;
`endif

    pc_unit dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .NPCOp(NPCOp), .BrTaken(BrTaken),
        .Imm16(Imm16), .Imm26(Imm26), .RegAddr(RegAddr), .ExcReq(ExcReq), .Eret(Eret),
        .PC(PC), .PC4(PC4), .EPC(EPC), .Redirect(Redirect), .InHandler(InHandler)
    );

    always #5 Clk = ~Clk;

    // Reference model in byte addresses.
    logic [31:0] m_pc, m_epc, m_seq, m_tgt;
    logic        m_inh, m_redir, m_exc, m_eret;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_pc = 32'h3000; m_epc = 0; m_inh = 0; m_redir = 0;
        end else begin
            m_seq = m_pc + 32'd4;
            case (NPCOp)
                2'd0: m_tgt = m_seq;
                2'd1: m_tgt = BrTaken ? m_seq + ({{16{Imm16[15]}}, Imm16} << 2) : m_seq;
                2'd2: m_tgt = {m_seq[31:28], Imm26, 2'b00};
                default: m_tgt = {RegAddr[31:2], 2'b00};
            endcase
            m_exc  = EXC && !m_inh && (ExcReq || (!Stall && NPCOp == 2'd3 && RegAddr[1:0] != 2'b00));
            m_eret = EXC && m_inh && Eret;
            if (m_exc) begin
                m_epc = m_pc; m_inh = 1; m_tgt = 32'h4180;
                m_redir = (m_tgt != m_seq); m_pc = m_tgt;
            end else if (m_eret) begin
                m_inh = 0; m_tgt = m_epc;
                m_redir = (m_tgt != m_seq); m_pc = m_tgt;
            end else if (Stall) begin
                m_redir = 0;
            end else begin
                m_redir = (m_tgt != m_seq); m_pc = m_tgt;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic run_chk = 1'b0;
    always @(negedge Clk) begin
        if (run_chk) begin
            chk("model_pc",  {PC, 2'b00}, m_pc);
            chk("model_pc4", {PC4, 2'b00}, m_pc + 32'd4);
            chk("model_epc", {EPC, 2'b00}, m_epc);
            chk("model_inh", {31'b0, InHandler}, {31'b0, m_inh});
            chk("model_redir", {31'b0, Redirect}, {31'b0, m_redir});
        end
    end

    task automatic cyc(input logic [1:0] op, input logic [31:0] ra = 0, input logic br = 0,
                       input logic [15:0] i16 = 0, input logic [25:0] i26 = 0,
                       input logic st = 0, input logic ex = 0, input logic er = 0);
        NPCOp = op; RegAddr = ra; BrTaken = br; Imm16 = i16; Imm26 = i26;
        Stall = st; ExcReq = ex; Eret = er;
        @(posedge Clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] pc_exp, input logic rd_exp);
        chk({name, "_pc"}, {PC, 2'b00}, pc_exp);
        chk({name, "_redir"}, {31'b0, Redirect}, {31'b0, rd_exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        run_chk = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        lit("in_reset", 32'h3000, 0);
        chk("in_reset_epc", {EPC, 2'b00}, 32'h0);
        chk("in_reset_inh", {31'b0, InHandler}, 32'h0);
        Reset = 1'b1;
        #1;
        lit("first_fetch", 32'h3000, 0);
        cyc(NPC_SEQ); lit("seq1", 32'h3004, 0);
        cyc(NPC_SEQ); lit("seq2", 32'h3008, 0);
        cyc(NPC_SEQ); lit("seq3", 32'h300C, 0);
        chk("pc4_seq3", {PC4, 2'b00}, 32'h3010);
        cyc(NPC_SEQ); lit("seq4", 32'h3010, 0);

        cyc(NPC_BR, 0, 1, 16'hFFFC); lit("br_taken", 32'h3004, 1);
        cyc(NPC_JR, 32'h3010);        lit("jr_3010", 32'h3010, 1);
        cyc(NPC_BR, 0, 0, 16'hFFFC); lit("br_not_taken", 32'h3014, 0);

        cyc(NPC_JR, 32'h3020);                 lit("jr_3020", 32'h3020, 1);
        cyc(NPC_J, 0, 0, 0, 26'h0000C40);      lit("jump", 32'h3100, 1);
        cyc(NPC_JR, 32'h3400);                 lit("jr_3400", 32'h3400, 1);
        cyc(NPC_JR, 32'h3000, 0, 0, 0, 1);     lit("stall_jr", 32'h3400, 0);

        cyc(NPC_JR, 32'h3040); lit("jr_3040", 32'h3040, 1);
        cyc(NPC_SEQ, 0, 0, 0, 0, 1, 1);
        if (EXC) begin
            lit("exc_over_stall", 32'h4180, 1);
            chk("exc_epc", {EPC, 2'b00}, 32'h3040);
            chk("exc_inh", {31'b0, InHandler}, 32'h1);
            cyc(NPC_SEQ, 0, 0, 0, 0, 0, 1); lit("exc_nested_ignored", 32'h4184, 0);
            chk("nested_epc", {EPC, 2'b00}, 32'h3040);
            cyc(NPC_SEQ, 0, 0, 0, 0, 0, 0, 1); lit("eret", 32'h3040, 1);
            chk("eret_inh", {31'b0, InHandler}, 32'h0);
            cyc(NPC_SEQ, 0, 0, 0, 0, 0, 0, 1); lit("eret_in_run", 32'h3044, 0);
            cyc(NPC_JR, 32'h3050); lit("jr_3050", 32'h3050, 1);
            cyc(NPC_JR, 32'h3402); lit("jr_misalign_trap", 32'h4180, 1);
            chk("trap_epc", {EPC, 2'b00}, 32'h3050);
            cyc(NPC_JR, 32'h3402); lit("jr_misalign_handler", 32'h3400, 1);
            cyc(NPC_SEQ, 0, 0, 0, 0, 1); lit("stall_handler", 32'h3400, 0);
            cyc(NPC_SEQ, 0, 0, 0, 0, 1, 0, 1); lit("eret_over_stall", 32'h3050, 1);
        end else begin
            lit("exc_ignored_stall", 32'h3040, 0);
            chk("noexc_epc", {EPC, 2'b00}, 32'h0);
            cyc(NPC_JR, 32'h3402); lit("jr_misalign_drop", 32'h3400, 1);
        end

        cyc(NPC_JR, 32'hFFFF_FFFC); lit("jr_top", 32'hFFFF_FFFC, 1);
        chk("pc4_wrap", {PC4, 2'b00}, 32'h0);
        cyc(NPC_SEQ); lit("wrap", 32'h0, 0);
        cyc(NPC_JR, 32'h7FFF_FFF0); lit("jr_7fff", 32'h7FFF_FFF0, 1);
        cyc(NPC_J, 0, 0, 0, 26'h5); lit("jump_region", 32'h7000_0014, 1);

        cyc(NPC_SEQ, 0, 0, 0, 0, 0, 1);
        lit("pre_reset", EXC ? 32'h4180 : 32'h7000_0018, EXC);
        #2;
        Reset = 1'b0;
        #1;
        lit("async_reset", 32'h3000, 0);
        chk("async_reset_inh", {31'b0, InHandler}, 32'h0);
        chk("async_reset_epc", {EPC, 2'b00}, 32'h0);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        cyc(NPC_SEQ); lit("after_reset", 32'h3004, 0);
        cyc(NPC_SEQ); lit("after_reset2", 32'h3008, 0);

        @(negedge Clk);
        #1;
        run_chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle MIPS datapath; replaces the plain NextPC register. Holds the current fetch address and computes the next one internally from sequential, branch, jump and register-jump sources. Adds stall hold, an exception vector with EPC capture and ERET return, and a one-cycle redirect flag. Feeds the instruction memory address and the link (PC+4) path.

## Interface
- ADDR_W, 32: address width in bits; PC is held word-aligned as [ADDR_W-1:2]
- RESET_PC, 32'h0000_3000: fetch address after reset
- EXC_VECTOR, 32'h0000_4180: exception handler entry address
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Stall  in  1  hold PC this cycle
- NPCOp  in  2  00 sequential, 01 branch, 10 jump (J/JAL), 11 register jump (JR/JALR)
- BrTaken  in  1  branch condition; qualifies NPCOp=01
- Imm16  in  16  branch offset, in words
- Imm26  in  26  jump index
- RegAddr  in  ADDR_W  register-jump target (rs)
- ExcReq  in  1  exception request (PC_EXC_EN only)
- Eret  in  1  return from handler (PC_EXC_EN only)
- PC  out  ADDR_W-2  current fetch address [ADDR_W-1:2]
- PC4  out  ADDR_W-2  PC+1 word, combinational, link value
- EPC  out  ADDR_W-2  saved exception PC (PC_EXC_EN only)
- Redirect  out  1  registered; high the cycle after a non-sequential PC load
- InHandler  out  1  FSM in HANDLER state (PC_EXC_EN only)

## Operation
- Next-PC priority, highest first: ExcReq (RUN state), Eret (HANDLER state), Stall, NPCOp.
- Sequential: PC+1. Branch taken: PC+1+sext(Imm16). Branch not taken: PC+1. Jump: {PC4[ADDR_W-1:28], Imm26}. Register: RegAddr[ADDR_W-1:2].
- All arithmetic modulo 2^(ADDR_W-2); PC at all-ones wraps to 0, no flag.
- FSM states RUN, HANDLER. RUN --ExcReq--> HANDLER: PC <= EXC_VECTOR, EPC <= PC. HANDLER --Eret--> RUN: PC <= EPC.
- ExcReq in HANDLER ignored (no nesting); PC follows normal rules. Eret in RUN ignored; PC follows normal rules.
- JR with RegAddr[1:0] != 0: in RUN raises an internal exception identical to ExcReq (EPC <= PC); in HANDLER low bits dropped.
- Stall holds PC, EPC, state; overridden by ExcReq/Eret.
- Redirect <= 1 when the loaded PC differs from the PC+1 value (branch taken, jump, JR, exception, ERET) and Stall not winning; else 0.

## Timing
- PC, EPC, state, Redirect update on Clk rising edge; all control inputs sampled same cycle (zero-latency select, one-cycle register).
- PC4 combinational from PC.
- Reset low (asynchronous, any time incl. mid-handler): PC = RESET_PC[ADDR_W-1:2], EPC = 0, state RUN, Redirect = 0, InHandler = 0. Release synchronous to next edge; first fetch at RESET_PC.

## Configuration
- PC_EXC_EN defined: RUN/HANDLER FSM, EPC register, ExcReq/Eret, misaligned-JR trap, InHandler all present.
- Undefined: no FSM or EPC; ExcReq/Eret ports present but ignored; EPC and InHandler tied 0; misaligned JR drops low bits.

## Structure
- Shared package/header: NPCOp encodings (NPC_SEQ, NPC_BR, NPC_J, NPC_JR), FSM state encodings, default RESET_PC and EXC_VECTOR.
- One sub-module natural: npc_calc, combinational next-address computation (seq/branch/jump/register targets); pc_unit keeps registers, priority and FSM.

## Test plan
- Reset low then high, NPCOp=00 four cycles -> PC 0x3000, 0x3004, 0x3008, 0x300C; Redirect 0.
- PC 0x3010, NPCOp=01, BrTaken=1, Imm16=16'hFFFC -> PC 0x3004, Redirect 1 next cycle; BrTaken=0 -> 0x3014.
- PC 0x3020, NPCOp=10, Imm26=26'h0000C40 -> PC 0x3100; NPCOp=11, RegAddr=0x3400 -> 0x3400; Stall=1 with NPCOp=11 -> PC unchanged.
- PC_EXC_EN: PC 0x3040, ExcReq=1 with Stall=1 -> PC 0x4180, EPC 0x3040, InHandler 1; second ExcReq ignored; Eret -> PC 0x3040, InHandler 0.
- PC_EXC_EN: NPCOp=11, RegAddr=0x3402 at PC 0x3050 -> PC 0x4180, EPC 0x3050.
- PC 0xFFFF_FFFC, NPCOp=00 -> PC 0x0000_0000; assert Reset low mid-handler -> PC 0x3000, InHandler 0 immediately.
